uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 172 +++++++++++++++++
 tb/tb_uart_tx.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx -- serial transmitter with optional parity and 1 or 2 stop bits.
//
// Frame on the line: start(0), 8 data bits LSB first, optional parity bit,
// STOP_BITS stop bits(1). Every bit lasts DIV_eff = max(DIV,2) clocks, where
// DIV is captured together with the byte at acceptance.
//
// Parameters:
//   PARITY_EN  : 1 inserts a parity bit after the data bits
//   PARITY_ODD : 1 selects odd parity, 0 even (ignored when PARITY_EN=0)
//   STOP_BITS  : number of stop bits, 1 or 2
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   DIV      in   [7:0] clocks per bit, captured at acceptance
//   tx_data  in   [7:0] byte to send, captured at acceptance
//   tx_valid in   tx_data is valid
//   tx_ready out  block can accept a byte (IDLE and not in reset)
//   uart_txd out  serial line, registered, idles high
//   tx_busy  out  a frame is on the line
//   tx_done  out  one-cycle pulse in the first IDLE cycle after a frame
// ---------------------------------------------------------------------------
module uart_tx #(
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] DIV,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       uart_txd,
  output logic       tx_busy,
  output logic       tx_done
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // The bit counter doubles as the stop-bit counter while in STOP.
  localparam logic [3:0] LAST_STOP = (STOP_BITS == 2) ? 4'd1 : 4'd0;
  localparam logic       HAS_PAR   = (PARITY_EN != 0);
  localparam logic       PAR_INV   = (PARITY_ODD != 0);

  state_t     r_state;
  state_t     w_nextState;
  logic [7:0] r_cnt;
  logic [7:0] r_divEff;
  logic [3:0] r_bitCnt;
  logic [7:0] r_shift;
  logic       r_parity;
  logic       r_txd;
  logic       r_done;

  logic       w_accept;
  logic       w_wrap;
  logic [7:0] w_divEff;
  logic       w_txdNext;
  logic       w_doneNext;

  assign tx_ready = (r_state == IDLE) && !rst;
  assign tx_busy  = (r_state != IDLE);
  assign uart_txd = r_txd;
  assign tx_done  = r_done;

  assign w_accept = tx_valid && tx_ready;
  assign w_divEff = (DIV < 8'd2) ? 8'd2 : DIV;
  assign w_wrap   = (r_cnt == (r_divEff - 8'd1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: every non-IDLE state advances only on a counter wrap,
  // so each bit occupies exactly DIV_eff cycles.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:   if (w_accept) w_nextState = START;
      START:  if (w_wrap) w_nextState = DATA;
      DATA:   if (w_wrap && (r_bitCnt == 4'd7)) w_nextState = HAS_PAR ? PARITY : STOP;
      PARITY: if (w_wrap) w_nextState = STOP;
      STOP:   if (w_wrap && (r_bitCnt == LAST_STOP)) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Output logic: the line value for the coming cycle is derived from the
  // next state so the registered line lines up with the state it belongs to.
  // At a data-bit boundary the shifter has not moved yet, so the next bit is
  // taken from position 1.
  always_comb begin
    w_txdNext  = 1'b1;
    w_doneNext = (r_state == STOP) && (w_nextState == IDLE);
    case (w_nextState)
      START:   w_txdNext = 1'b0;
      DATA:    w_txdNext = ((r_state == DATA) && w_wrap) ? r_shift[1] : r_shift[0];
      PARITY:  w_txdNext = r_parity;
      default: w_txdNext = 1'b1;
    endcase
  end

  // Registered line and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_txd  <= 1'b1;
      r_done <= 1'b0;
    end else begin
      r_txd  <= w_txdNext;
      r_done <= w_doneNext;
    end
  end

  // Cycle counter: held at 0 in IDLE, otherwise counts 0..DIV_eff-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 8'd0;
    end else if (r_state == IDLE) begin
      r_cnt <= 8'd0;
    end else if (w_wrap) begin
      r_cnt <= 8'd0;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // Bit counter: data bit index in DATA, stop bit index in STOP; cleared
  // whenever the state changes so each use starts from 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bitCnt <= 4'd0;
    end else if (((r_state == DATA) || (r_state == STOP)) && w_wrap) begin
      if (w_nextState != r_state) begin
        r_bitCnt <= 4'd0;
      end else begin
        r_bitCnt <= r_bitCnt + 4'd1;
      end
    end else if ((r_state != DATA) && (r_state != STOP)) begin
      r_bitCnt <= 4'd0;
    end
  end

  // Byte capture: shifter, divider and parity are all frozen at acceptance
  // so input changes during a frame cannot disturb it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift  <= 8'd0;
      r_divEff <= 8'd2;
      r_parity <= 1'b0;
    end else if (w_accept) begin
      r_shift  <= tx_data;
      r_divEff <= w_divEff;
      r_parity <= (^tx_data) ^ PAR_INV;
    end else if ((r_state == DATA) && w_wrap) begin
      r_shift  <= r_shift >> 1;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx -- directed self-checking bench for uart_tx.
//
// Three instances cover the parameter space: dut0 defaults, dut1 even
// parity, dut2 odd parity with two stop bits. Only one instance is driven at
// a time; the others sit idle. Inputs change #1 after a rising edge (or on a
// falling edge), outputs are sampled on falling edges.
// ---------------------------------------------------------------------------
module tb_uart_tx;

  logic       clk;
  logic       rst;
  logic [7:0] DIV;
  logic [7:0] txData;
  logic [2:0] txValid;
  logic [2:0] txReady;
  logic [2:0] txd;
  logic [2:0] busy;
  logic [2:0] done;

  int vecCount  = 0;
  int missCount = 0;

  uart_tx #(.PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .DIV(DIV), .tx_data(txData), .tx_valid(txValid[0]),
    .tx_ready(txReady[0]), .uart_txd(txd[0]), .tx_busy(busy[0]), .tx_done(done[0])
  );

  uart_tx #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .DIV(DIV), .tx_data(txData), .tx_valid(txValid[1]),
    .tx_ready(txReady[1]), .uart_txd(txd[1]), .tx_busy(busy[1]), .tx_done(done[1])
  );

  uart_tx #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .DIV(DIV), .tx_data(txData), .tx_valid(txValid[2]),
    .tx_ready(txReady[2]), .uart_txd(txd[2]), .tx_busy(busy[2]), .tx_done(done[2])
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts one comparison and reports it when the values differ.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Presents one byte to instance sel and releases tx_valid after the
  // accepting edge; returns #1 after that edge.
  task automatic applyStimulus(input int sel, input logic [7:0] data, input logic [7:0] div);
    @(posedge clk);
    #1;
    txData       = data;
    DIV          = div;
    txValid[sel] = 1'b1;
    checkOutput($sformatf("d%0d ready before accept", sel), 32'(txReady[sel]), 32'd1);
    @(posedge clk);
    #1;
    txValid[sel] = 1'b0;
  endtask

  // Expected line level for a given bit slot of a frame.
  function automatic logic expBit(input logic [7:0] data, input bit parEn,
                                  input logic parBit, input int slot);
    if (slot == 0) return 1'b0;
    if (slot <= 8) return data[slot-1];
    if (parEn && slot == 9) return parBit;
    return 1'b1;
  endfunction

  // Follows one frame cycle by cycle, starting just after the accepting edge.
  // chained: return in the done cycle so the caller can launch the next byte.
  // disturb: scramble tx_data/DIV/tx_valid mid-frame to show they are ignored.
  task automatic checkFrame(input int sel, input logic [7:0] data, input int divEff,
                            input bit parEn, input logic parBit, input int stopBits,
                            input bit chained, input bit disturb);
    int frameLen;
    frameLen = (9 + int'(parEn) + stopBits) * divEff;
    for (int c = 1; c <= frameLen; c++) begin
      @(negedge clk);
      checkOutput($sformatf("d%0d %02h txd c%0d", sel, data, c), 32'(txd[sel]),
                  32'(expBit(data, parEn, parBit, (c - 1) / divEff)));
      if (c == 1 || c == frameLen) begin
        checkOutput($sformatf("d%0d busy c%0d", sel, c), 32'(busy[sel]), 32'd1);
        checkOutput($sformatf("d%0d ready c%0d", sel, c), 32'(txReady[sel]), 32'd0);
        checkOutput($sformatf("d%0d done c%0d", sel, c), 32'(done[sel]), 32'd0);
      end
      if (disturb && c == 3 * divEff) begin
        txData       = ~txData;
        DIV          = 8'd3;
        txValid[sel] = 1'b1;
      end
      if (disturb && c == frameLen) txValid[sel] = 1'b0;
    end
    @(negedge clk);
    checkOutput($sformatf("d%0d done pulse", sel), 32'(done[sel]), 32'd1);
    checkOutput($sformatf("d%0d busy after", sel), 32'(busy[sel]), 32'd0);
    checkOutput($sformatf("d%0d ready after", sel), 32'(txReady[sel]), 32'd1);
    if (!chained) begin
      @(negedge clk);
      checkOutput($sformatf("d%0d done single", sel), 32'(done[sel]), 32'd0);
      checkOutput($sformatf("d%0d txd idle", sel), 32'(txd[sel]), 32'd1);
    end
  endtask

  initial begin
    rst     = 1'b1;
    DIV     = 8'd10;
    txData  = 8'h00;
    txValid = 3'b000;

    // Reset state, including tx_ready forced low while rst is high.
    repeat (3) @(negedge clk);
    checkOutput("rst txd", 32'(txd[0]), 32'd1);
    checkOutput("rst ready", 32'(txReady[0]), 32'd0);
    checkOutput("rst busy", 32'(busy[0]), 32'd0);
    checkOutput("rst done", 32'(done[0]), 32'd0);
    checkOutput("rst ready d2", 32'(txReady[2]), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post-rst ready", 32'(txReady[0]), 32'd1);
    checkOutput("post-rst txd", 32'(txd[0]), 32'd1);

    // Basic frame: 0x55 at DIV=10, done in cycle 101.
    applyStimulus(0, 8'h55, 8'd10);
    checkFrame(0, 8'h55, 10, 1'b0, 1'b0, 1, 1'b0, 1'b0);

    // Even parity on 0x07 -> parity bit 1, 110 cycles.
    applyStimulus(1, 8'h07, 8'd10);
    checkFrame(1, 8'h07, 10, 1'b1, 1'b1, 1, 1'b0, 1'b0);

    // Odd parity on 0x07 -> parity bit 0, two 10-cycle stop bits, with
    // tx_data/DIV/tx_valid scrambled mid-frame.
    applyStimulus(2, 8'h07, 8'd10);
    checkFrame(2, 8'h07, 10, 1'b1, 1'b0, 2, 1'b0, 1'b1);

    // Back-to-back: tx_valid held across two frames at DIV=4.
    @(posedge clk);
    #1;
    txData     = 8'hA5;
    DIV        = 8'd4;
    txValid[0] = 1'b1;
    @(posedge clk);
    #1;
    txData = 8'h3C;
    checkFrame(0, 8'hA5, 4, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    txValid[0] = 1'b0;
    checkFrame(0, 8'h3C, 4, 1'b0, 1'b0, 1, 1'b0, 1'b0);

    // Reset during data bit 3 of 0xF0 (bit 3 = 0, cycles 17..20 at DIV=4).
    applyStimulus(0, 8'hF0, 8'd4);
    repeat (18) @(negedge clk);
    checkOutput("mid txd bit3", 32'(txd[0]), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort txd", 32'(txd[0]), 32'd1);
    checkOutput("abort busy", 32'(busy[0]), 32'd0);
    checkOutput("abort ready", 32'(txReady[0]), 32'd0);
    checkOutput("abort done", 32'(done[0]), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("release ready", 32'(txReady[0]), 32'd1);
    checkOutput("release txd", 32'(txd[0]), 32'd1);
    checkOutput("release done", 32'(done[0]), 32'd0);
    applyStimulus(0, 8'hFF, 8'd4);
    checkFrame(0, 8'hFF, 4, 1'b0, 1'b0, 1, 1'b0, 1'b0);

    // DIV 0 and 1 both behave as 2.
    applyStimulus(0, 8'h96, 8'd0);
    checkFrame(0, 8'h96, 2, 1'b0, 1'b0, 1, 1'b0, 1'b0);
    applyStimulus(0, 8'h69, 8'd1);
    checkFrame(0, 8'h69, 2, 1'b0, 1'b0, 1, 1'b0, 1'b0);

    // Extra parity vectors: 0x00 even -> 0, 0x81 even -> 0, 0x03 odd -> 1.
    applyStimulus(1, 8'h00, 8'd3);
    checkFrame(1, 8'h00, 3, 1'b1, 1'b0, 1, 1'b0, 1'b0);
    applyStimulus(1, 8'h81, 8'd5);
    checkFrame(1, 8'h81, 5, 1'b1, 1'b0, 1, 1'b0, 1'b0);
    applyStimulus(2, 8'h03, 8'd2);
    checkFrame(2, 8'h03, 2, 1'b1, 1'b1, 2, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
